// File: rtl/rightram_pkg.sv
// Shared definitions for the camera frame-RAM read arbiters: owner codes,
// arbiter states and the tag carried alongside each RAM read.
package rightram_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VGA  = 2'd1;
    localparam logic [1:0] OWN_DIST = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [1:0] owner;
        logic       last;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{owner: OWN_NONE, last: 1'b0};

    // A tag belonging to the flushed owner is turned into an empty slot.
    function automatic rd_tag_t scrub_tag(input rd_tag_t t, input logic flush,
                                          input logic [1:0] own);
        return (flush && (t.owner == own)) ? TAG_NONE : t;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth tag shift register that tracks the owner of every RAM read in
// flight; a flush rewrites all tags of one owner (including the exiting one).
module rd_tag_pipe
    import rightram_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  rd_tag_t    push_tag,
    input  logic       flush,
    input  logic [1:0] flush_owner,
    output rd_tag_t    out_tag
);

    rd_tag_t [DEPTH-1:0] tag_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= scrub_tag(push_tag, flush, flush_owner);
            for (int i = 1; i < int'(DEPTH); i++)
                tag_pipe[i] <= scrub_tag(tag_pipe[i-1], flush, flush_owner);
        end
    end

    // The exiting tag is masked too, so a flush suppresses the very next return.
    assign out_tag = scrub_tag(tag_pipe[DEPTH-1], flush, flush_owner);

endmodule

// File: rtl/rightram_rd_arbiter.sv
// Right-camera frame RAM read-port arbiter: VGA scanout always wins, the
// distance engine's bursts fill idle cycles, returns are routed by tag.
module rightram_rd_arbiter
    import rightram_pkg::*;
#(
    parameter int unsigned   RD_LAT   = 2,
    parameter int unsigned   AW       = AW_DEF,
    parameter int unsigned   DW       = DW_DEF,
    parameter logic [AW-1:0] ADDR_MAX = {AW{1'b1}}
) (
    input  logic          vclk,
    input  logic          reset,
    input  logic          vga_rden,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    output logic          vga_valid,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_len,
    input  logic          cmd_abort,
    output logic [DW-1:0] dist_data,
    output logic          dist_valid,
    output logic          dist_last,
    output logic          busy,
    output logic [AW-1:0] rdaddress,
    output logic          rden,
    output logic          rdclock,
    input  logic [DW-1:0] q
);

    arb_state_t    state;
    logic [AW-1:0] cur_addr;
    logic [8:0]    remaining;
    logic          dist_issue;
    logic          flush;
    rd_tag_t       push_tag;
    rd_tag_t       out_tag;

    assign dist_issue = (state == BURST) && !vga_rden;
    assign flush      = cmd_abort && (state != IDLE);
    assign rden       = vga_rden | dist_issue;
    assign rdaddress  = vga_rden ? vga_addr : cur_addr;
    assign rdclock    = vclk;

    always_comb begin
        push_tag = TAG_NONE;
        if (vga_rden) begin
            push_tag.owner = OWN_VGA;
        end else if (dist_issue) begin
            push_tag.owner = OWN_DIST;
            push_tag.last  = (remaining == 9'd1);
        end
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .clk         (vclk),
        .reset       (reset),
        .push_tag    (push_tag),
        .flush       (flush),
        .flush_owner (OWN_DIST),
        .out_tag     (out_tag)
    );

    always_ff @(posedge vclk) begin
        if (reset) begin
            vga_valid  <= 1'b0;
            vga_data   <= '0;
            dist_valid <= 1'b0;
            dist_last  <= 1'b0;
            dist_data  <= '0;
        end else begin
            vga_valid  <= (out_tag.owner == OWN_VGA);
            dist_valid <= (out_tag.owner == OWN_DIST);
            dist_last  <= (out_tag.owner == OWN_DIST) && out_tag.last;
            if (out_tag.owner == OWN_VGA)
                vga_data <= q;
            if (out_tag.owner == OWN_DIST)
                dist_data <= q;
        end
    end

    // cmd_ready stays low through reset and rises on the first cycle after it.
    always_ff @(posedge vclk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cur_addr  <= cmd_addr;
                        remaining <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
                        state     <= BURST;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BURST: begin
                    if (cmd_abort) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (dist_issue) begin
                        cur_addr  <= (cur_addr == ADDR_MAX) ? '0
                                   : cur_addr + {{(AW-1){1'b0}}, 1'b1};
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cmd_abort || dist_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rightram_rd_arbiter.sv
// Bench for rightram_rd_arbiter: a return schedule indexed by cycle predicts
// every output, with directed bursts and a randomized traffic phase.
module tb_rightram_rd_arbiter;

    localparam int L  = 2;
    localparam int AW = 16;
    localparam int DW = 3;
    localparam int NC = 8192;

    logic          vclk = 1'b0;
    logic          reset, vga_rden, cmd_valid, cmd_abort;
    logic [AW-1:0] vga_addr, cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] vga_data, dist_data, q;
    logic          vga_valid, cmd_ready, dist_valid, dist_last, busy, rden, rdclock;
    logic [AW-1:0] rdaddress;

    always #5 vclk = ~vclk;

    rightram_rd_arbiter #(.RD_LAT(L)) dut (
        .vclk(vclk), .reset(reset), .vga_rden(vga_rden), .vga_addr(vga_addr),
        .vga_data(vga_data), .vga_valid(vga_valid), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_abort(cmd_abort), .dist_data(dist_data), .dist_valid(dist_valid),
        .dist_last(dist_last), .busy(busy), .rdaddress(rdaddress), .rden(rden),
        .rdclock(rdclock), .q(q)
    );

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[15:13];
    endfunction

    // RAM: q shows the word addressed L edges earlier.
    logic [AW-1:0] ram_pipe [L];
    always @(posedge vclk) begin
        ram_pipe[0] <= rdaddress;
        for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign q = pix(ram_pipe[L-1]);

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Model: what the arbiter owes, and which cycle each return is due on.
    bit          accepting, active;
    int          left, last_due;
    logic [15:0] m_addr;
    logic [2:0]  m_vd, m_dd;
    bit          s_vga_v [NC];
    logic [2:0]  s_vga_d [NC];
    bit          s_dst_v [NC];
    bit          s_dst_l [NC];
    logic [2:0]  s_dst_d [NC];

    logic [15:0] iss_a[$];
    int          iss_c[$], dv_c[$], dl_c[$];
    int          nvga, busy_fall;
    bit          prev_busy, cur_ready, cur_busy, cur_dv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        iss_a.delete(); iss_c.delete(); dv_c.delete(); dl_c.delete();
        nvga = 0; busy_fall = -1;
    endtask

    task automatic tick(input bit rst, input bit vr, input logic [15:0] va,
                        input bit cv, input logic [15:0] ca, input logic [7:0] cl,
                        input bit ab);
        bit issue;
        @(negedge vclk);
        reset = rst; vga_rden = vr; vga_addr = va;
        cmd_valid = cv; cmd_addr = ca; cmd_len = cl; cmd_abort = ab;
        #1;
        issue = active && (left > 0) && !vr;
        if (cyc > 0) begin
            chk("rden", rden, vr | issue);
            if (vr | issue) chk("rdaddress", rdaddress, vr ? va : m_addr);
            chk("cmd_ready", cmd_ready, accepting);
            chk("busy", busy, active);
            chk("vga_valid", vga_valid, s_vga_v[cyc]);
            if (s_vga_v[cyc]) m_vd = s_vga_d[cyc];
            chk("vga_data", vga_data, m_vd);
            chk("dist_valid", dist_valid, s_dst_v[cyc]);
            if (s_dst_v[cyc]) m_dd = s_dst_d[cyc];
            chk("dist_data", dist_data, m_dd);
            chk("dist_last", dist_last, s_dst_l[cyc]);
        end
        cur_ready = cmd_ready; cur_busy = busy; cur_dv = dist_valid;
        if (rden && !vga_rden) begin iss_a.push_back(rdaddress); iss_c.push_back(cyc); end
        if (dist_valid) dv_c.push_back(cyc);
        if (dist_last) dl_c.push_back(cyc);
        if (vga_valid) nvga++;
        if (!busy && prev_busy) busy_fall = cyc;
        prev_busy = busy;
        // advance the model across the coming edge
        if (rst) begin
            for (int k = cyc + 1; k <= cyc + L + 1; k++) begin
                s_vga_v[k] = 0; s_dst_v[k] = 0; s_dst_l[k] = 0;
            end
            accepting = 0; active = 0; left = 0; last_due = -1; m_vd = '0; m_dd = '0;
        end else begin
            if (vr) begin s_vga_v[cyc+L+1] = 1; s_vga_d[cyc+L+1] = pix(va); end
            if (ab && active) begin
                for (int k = cyc + 1; k <= cyc + L + 1; k++) begin
                    s_dst_v[k] = 0; s_dst_l[k] = 0;
                end
            end else if (issue) begin
                s_dst_v[cyc+L+1] = 1; s_dst_d[cyc+L+1] = pix(m_addr);
                s_dst_l[cyc+L+1] = (left == 1);
            end
            if (!active) begin
                if (accepting && cv) begin
                    active = 1; accepting = 0; m_addr = ca;
                    left = (cl == 0) ? 256 : int'(cl);
                end else accepting = 1;
            end else if (ab) begin
                active = 0; accepting = 1; left = 0; last_due = -1;
            end else if (left > 0) begin
                if (issue) begin
                    m_addr = (m_addr == 16'hFFFF) ? 16'h0000 : m_addr + 16'h0001;
                    left--;
                    if (left == 0) last_due = cyc + L + 1;
                end
            end else if (cyc == last_due) begin
                active = 0; accepting = 1; last_due = -1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 16'h0, 0, 16'h0, 8'h0, 0);
    endtask

    task automatic cmd(input logic [15:0] a, input logic [7:0] l);
        tick(0, 0, 16'h0, 1, a, l, 0);
    endtask

    initial begin
        accepting = 0; active = 0; left = 0; last_due = -1;
        m_addr = '0; m_vd = '0; m_dd = '0; prev_busy = 0;
        for (int k = 0; k < NC; k++) begin
            s_vga_v[k] = 0; s_dst_v[k] = 0; s_dst_l[k] = 0;
            s_vga_d[k] = '0; s_dst_d[k] = '0;
        end
        clear_logs();

        tick(1, 0, 16'h0, 0, 16'h0, 8'h0, 0);
        tick(1, 0, 16'h0, 0, 16'h0, 8'h0, 0);
        idle(1);
        chk("ready_after_reset", cmd_ready, 1'b0);

        // plain 4-word burst
        clear_logs();
        cmd(16'h0100, 8'd4);
        idle(12);
        chk("t1_issues", iss_a.size(), 4);
        if (iss_a.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t1_addr", iss_a[i], 16'h0100 + i);
            chk("t1_consecutive", iss_c[3] - iss_c[0], 3);
        end
        chk("t1_dvalid_cnt", dv_c.size(), 4);
        chk("t1_dlast_cnt", dl_c.size(), 1);
        if (dv_c.size() == 4 && dl_c.size() == 1 && iss_c.size() > 0) begin
            chk("t1_latency", dv_c[0] - iss_c[0], 3);
            chk("t1_last_on_4th", dl_c[0], dv_c[3]);
            chk("t1_busy_fall", busy_fall - dl_c[0], 1);
        end

        // VGA interleaved with a 3-word burst
        clear_logs();
        cmd(16'h0200, 8'd3);
        for (int i = 0; i < 8; i++)
            tick(0, (i < 6) && (i % 2 == 0), 16'h3000 + 16'(i), 0, 16'h0, 8'h0, 0);
        idle(8);
        chk("t2_issues", iss_a.size(), 3);
        if (iss_a.size() == 3)
            for (int i = 0; i < 3; i++) chk("t2_addr", iss_a[i], 16'h0200 + i);
        chk("t2_dvalid_cnt", dv_c.size(), 3);
        chk("t2_vga_cnt", nvga, 3);

        // address wrap
        clear_logs();
        cmd(16'hFFFE, 8'd3);
        idle(10);
        chk("t3_issues", iss_a.size(), 3);
        if (iss_a.size() == 3) begin
            chk("t3_a0", iss_a[0], 16'hFFFE);
            chk("t3_a1", iss_a[1], 16'hFFFF);
            chk("t3_a2", iss_a[2], 16'h0000);
        end

        // len 0 = 256 words
        clear_logs();
        cmd(16'h1234, 8'd0);
        idle(270);
        chk("t4_dvalid_cnt", dv_c.size(), 256);
        chk("t4_dlast_cnt", dl_c.size(), 1);
        if (iss_a.size() == 256) chk("t4_final_addr", iss_a[255], 16'h1333);

        // abort with two dist reads in flight and a VGA read alongside
        clear_logs();
        cmd(16'h0400, 8'd8);
        idle(2);
        tick(0, 1, 16'h5555, 0, 16'h0, 8'h0, 1);
        idle(1);
        chk("t5_ready_next", cur_ready, 1'b1);
        chk("t5_busy_next", cur_busy, 1'b0);
        idle(7);
        chk("t5_issues", iss_a.size(), 2);
        chk("t5_dvalid_cnt", dv_c.size(), 0);
        chk("t5_dlast_cnt", dl_c.size(), 0);
        chk("t5_vga_cnt", nvga, 1);

        // reset during DRAIN
        cmd(16'h0600, 8'd2);
        idle(3);
        tick(1, 0, 16'h0, 0, 16'h0, 8'h0, 0);
        clear_logs();
        idle(1);
        chk("t6_ready_in_reset", cur_ready, 1'b0);
        chk("t6_busy_in_reset", cur_busy, 1'b0);
        chk("t6_dvalid_in_reset", cur_dv, 1'b0);
        idle(1);
        chk("t6_ready_after", cur_ready, 1'b1);
        idle(8);
        chk("t6_stale_dvalid", dv_c.size(), 0);

        // randomized traffic: VGA duty varies like active video vs blanking
        begin
            int duty;
            bit vr, cv, ab, rst;
            logic [15:0] va, ca;
            logic [7:0]  cl;
            duty = 30;
            for (int i = 0; i < 3000; i++) begin
                if (i % 64 == 0) begin
                    case ($urandom_range(0, 2))
                        0: duty = 0;
                        1: duty = 30;
                        default: duty = 90;
                    endcase
                end
                vr  = ($urandom_range(0, 99) < duty);
                va  = 16'($urandom);
                cv  = ($urandom_range(0, 9) < 3);
                ca  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                  : 16'($urandom);
                case ($urandom_range(0, 9))
                    0: cl = 8'd0;
                    1, 2: cl = 8'($urandom);
                    default: cl = 8'($urandom_range(1, 6));
                endcase
                ab  = ($urandom_range(0, 99) < 2);
                rst = ($urandom_range(0, 999) < 3);
                tick(rst, vr, va, cv, ca, cl, ab);
            end
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
